// File: rtl/timer_irq_ctrl_if.sv
// Peripheral bus seen by the timer block: read/write strobes, address, data.
interface timer_irq_ctrl_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output mem_rd, mem_wr, addr, wdata, input rdata);
  modport slave  (input mem_rd, mem_wr, addr, wdata, output rdata);
endinterface

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped reload timer with prescaler and a masked, non-reentrant
// interrupt request towards the CPU control unit.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PRESCALE  = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  timer_irq_ctrl_if.slave    bus,
  input  logic               i_kernel,
  input  logic               i_irq_ack,
  output logic               o_irq,
  output logic [31:0]        o_tick_cnt
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_PEND  = 2'd1;
  localparam logic [1:0]  S_SERV  = 2'd2;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [31:0] r_th, r_tl, r_irqcnt, r_tick_cnt;
  logic [15:0] r_pre;
  logic [1:0]  r_state;
  logic        r_en, r_ie, r_st, r_irq;

  logic        w_hit, w_wr, w_wr_th, w_wr_tl, w_wr_tcon;
  logic        w_tick, w_ovf, w_ack, w_insv, w_w1c, w_en_rise;
  logic [31:0] w_rdata;

  assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr      = bus.mem_wr & w_hit;
  assign w_wr_th   = w_wr & (bus.addr[3:2] == 2'd0);
  assign w_wr_tl   = w_wr & (bus.addr[3:2] == 2'd1);
  assign w_wr_tcon = w_wr & (bus.addr[3:2] == 2'd2);
  assign w_w1c     = w_wr_tcon & bus.wdata[2];
  assign w_en_rise = w_wr_tcon & bus.wdata[0] & ~r_en;

  assign w_tick = r_en & (r_pre == PRE_MAX);
  // A software TL write in the same cycle suppresses the increment and any overflow.
  assign w_ovf  = w_tick & ~w_wr_tl & (r_tl == 32'hFFFF_FFFF);
  assign w_insv = (r_state == S_SERV);
  assign w_ack  = i_irq_ack & (r_state == S_PEND);

  always_comb begin
    w_rdata = '0;
    if (bus.mem_rd && w_hit) begin
      case (bus.addr[3:2])
        2'd0:    w_rdata = r_th;
        2'd1:    w_rdata = r_tl;
        2'd2:    w_rdata = {28'd0, w_insv, r_st, r_ie, r_en};
        default: w_rdata = r_irqcnt;
      endcase
    end
  end

  assign bus.rdata  = w_rdata;
  assign o_irq      = r_irq & ~i_kernel;
  assign o_tick_cnt = r_tick_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_th       <= '0;
      r_tl       <= '0;
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_st       <= 1'b0;
      r_irq      <= 1'b0;
      r_irqcnt   <= '0;
      r_tick_cnt <= '0;
      r_pre      <= '0;
      r_state    <= S_IDLE;
    end else begin
      if (w_en_rise)   r_pre <= '0;
      else if (r_en)   r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;

      if (w_tick)      r_tick_cnt <= r_tick_cnt + 32'd1;
      if (w_wr_th)     r_th <= bus.wdata;

      // Reload reads r_th before this edge, so a same-cycle TH write is not seen.
      if (w_wr_tl)     r_tl <= bus.wdata;
      else if (w_tick) r_tl <= (r_tl == 32'hFFFF_FFFF) ? r_th : r_tl + 32'd1;

      if (w_wr_tcon)   {r_ie, r_en} <= bus.wdata[1:0];

      // Overflow beats both the W1C and the acknowledge clear, so no event is lost.
      if (w_ovf && r_ie)        r_st <= 1'b1;
      else if (w_ack || w_w1c)  r_st <= 1'b0;

      r_irq <= r_st & r_ie & ~w_insv;
      if (w_ack) r_irqcnt <= r_irqcnt + 32'd1;

      case (r_state)
        S_IDLE:  if (r_st && r_ie) r_state <= S_PEND;
        S_PEND:  if (w_ack)                r_state <= S_SERV;
                 else if (!r_st || !r_ie)  r_state <= S_IDLE;
        S_SERV:  if (!i_kernel) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
